// File: rtl/lcd_ctrl_gen_pkg.sv
// rtl/lcd_ctrl_gen_pkg.sv - shared command/state types and default sizes for lcd_ctrl_gen
// Optional feature macro: LCD_CTRL_ROTATE_EN (rotate commands 10/11).
package lcd_ctrl_gen_pkg;

  localparam int DEF_IMG_DIM = 8;
  localparam int DEF_PIX_W   = 8;

  typedef enum logic [3:0] {
    CMD_WRITE   = 4'd0,
    CMD_UP      = 4'd1,
    CMD_DOWN    = 4'd2,
    CMD_LEFT    = 4'd3,
    CMD_RIGHT   = 4'd4,
    CMD_AVG     = 4'd5,
    CMD_MIRX    = 4'd6,
    CMD_MIRY    = 4'd7,
    CMD_MAX     = 4'd8,
    CMD_MIN     = 4'd9,
    CMD_ROT_CCW = 4'd10,
    CMD_ROT_CW  = 4'd11
  } cmd_e;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    IDLE  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/lcd_win_alu.sv
// rtl/lcd_win_alu.sv - combinational 2x2 window arithmetic for lcd_ctrl_gen
// Rotate paths (cmds 10/11) exist only when LCD_CTRL_ROTATE_EN is defined.
module lcd_win_alu
  import lcd_ctrl_gen_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic [3:0]       cmd_i,
  input  logic [PIX_W-1:0] tl_i,
  input  logic [PIX_W-1:0] tr_i,
  input  logic [PIX_W-1:0] bl_i,
  input  logic [PIX_W-1:0] br_i,
  output logic [PIX_W-1:0] tl_o,
  output logic [PIX_W-1:0] tr_o,
  output logic [PIX_W-1:0] bl_o,
  output logic [PIX_W-1:0] br_o
);

  logic [PIX_W+1:0] sum;
  logic [PIX_W-1:0] mx_t, mx_b, mx, mn_t, mn_b, mn;

  always_comb begin
    sum  = {2'b00, tl_i} + {2'b00, tr_i} + {2'b00, bl_i} + {2'b00, br_i};
    mx_t = (tl_i > tr_i) ? tl_i : tr_i;
    mx_b = (bl_i > br_i) ? bl_i : br_i;
    mx   = (mx_t > mx_b) ? mx_t : mx_b;
    mn_t = (tl_i < tr_i) ? tl_i : tr_i;
    mn_b = (bl_i < br_i) ? bl_i : br_i;
    mn   = (mn_t < mn_b) ? mn_t : mn_b;

    // Pass-through is the default so moves and reserved codes leave pixels untouched.
    tl_o = tl_i;
    tr_o = tr_i;
    bl_o = bl_i;
    br_o = br_i;
    case (cmd_e'(cmd_i))
      CMD_AVG: begin
        tl_o = sum[PIX_W+1:2];
        tr_o = sum[PIX_W+1:2];
        bl_o = sum[PIX_W+1:2];
        br_o = sum[PIX_W+1:2];
      end
      CMD_MIRX: begin
        tl_o = bl_i; bl_o = tl_i;
        tr_o = br_i; br_o = tr_i;
      end
      CMD_MIRY: begin
        tl_o = tr_i; tr_o = tl_i;
        bl_o = br_i; br_o = bl_i;
      end
      CMD_MAX: begin
        tl_o = mx; tr_o = mx; bl_o = mx; br_o = mx;
      end
      CMD_MIN: begin
        tl_o = mn; tr_o = mn; bl_o = mn; br_o = mn;
      end
`ifdef LCD_CTRL_ROTATE_EN
      CMD_ROT_CCW: begin
        tl_o = tr_i; tr_o = br_i; br_o = bl_i; bl_o = tl_i;
      end
      CMD_ROT_CW: begin
        tl_o = bl_i; tr_o = tl_i; br_o = tr_i; bl_o = br_i;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/lcd_ctrl_gen.sv
// rtl/lcd_ctrl_gen.sv - LCD image controller: IROM load, 2x2 window commands, IRB dump
// Rotate commands are enabled by LCD_CTRL_ROTATE_EN (see lcd_win_alu).
module lcd_ctrl_gen
  import lcd_ctrl_gen_pkg::*;
#(
  parameter int IMG_DIM = DEF_IMG_DIM,
  parameter int PIX_W   = DEF_PIX_W,
  localparam int LW     = $clog2(IMG_DIM),
  localparam int AW     = 2 * LW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       cmd,
  input  logic             cmd_valid,
  input  logic [PIX_W-1:0] IROM_Q,
  output logic             IROM_EN,
  output logic [AW-1:0]    IROM_A,
  output logic             IRB_RW,
  output logic [PIX_W-1:0] IRB_D,
  output logic [AW-1:0]    IRB_A,
  output logic             busy,
  output logic             done
);

  localparam int            N         = IMG_DIM * IMG_DIM;
  localparam logic [AW-1:0] A_ONE     = AW'(1);
  localparam logic [AW-1:0] A_LAST    = AW'(N - 1);
  localparam logic [LW-1:0] P_ONE     = LW'(1);
  localparam logic [LW-1:0] P_MAX     = LW'(IMG_DIM - 1);
  localparam logic [LW-1:0] P_MID     = LW'(IMG_DIM / 2);

  state_e           state_q;
  logic [LW-1:0]    x_q, y_q;
  logic [3:0]       cmd_q;
  logic             irom_en_q, rd_vld_q, irb_rw_q, busy_q, done_q;
  logic [AW-1:0]    irom_a_q, rd_addr_q, irb_a_q;
  logic [PIX_W-1:0] irb_d_q;
  logic [PIX_W-1:0] buf_q [N];

  logic [AW-1:0]    a_tl, a_tr, a_bl, a_br, irb_nxt;
  logic [PIX_W-1:0] tl_d, tr_d, bl_d, br_d;

  // Row-major with power-of-two side, so an address is just {row, col}.
  assign a_tl    = {y_q - P_ONE, x_q - P_ONE};
  assign a_tr    = {y_q - P_ONE, x_q};
  assign a_bl    = {y_q, x_q - P_ONE};
  assign a_br    = {y_q, x_q};
  assign irb_nxt = irb_a_q + A_ONE;

  lcd_win_alu #(.PIX_W(PIX_W)) u_alu (
    .cmd_i (cmd_q),
    .tl_i  (buf_q[a_tl]),
    .tr_i  (buf_q[a_tr]),
    .bl_i  (buf_q[a_bl]),
    .br_i  (buf_q[a_br]),
    .tl_o  (tl_d),
    .tr_o  (tr_d),
    .bl_o  (bl_d),
    .br_o  (br_d)
  );

  always_ff @(posedge clk) begin
    if (state_q == LOAD && rd_vld_q) begin
      buf_q[rd_addr_q] <= IROM_Q;
    end else if (state_q == EXEC) begin
      buf_q[a_tl] <= tl_d;
      buf_q[a_tr] <= tr_d;
      buf_q[a_bl] <= bl_d;
      buf_q[a_br] <= br_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= LOAD;
      x_q       <= P_MID;
      y_q       <= P_MID;
      cmd_q     <= 4'd0;
      irom_en_q <= 1'b1;
      irom_a_q  <= '0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      irb_rw_q  <= 1'b1;
      irb_a_q   <= '0;
      irb_d_q   <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        LOAD: begin
          // IROM is synchronous: data for an address arrives one cycle later.
          rd_vld_q  <= ~irom_en_q;
          rd_addr_q <= irom_a_q;
          if (irom_en_q) irom_en_q <= 1'b0;
          else if (irom_a_q != A_LAST) irom_a_q <= irom_a_q + A_ONE;
          if (rd_vld_q && rd_addr_q == A_LAST) begin
            irom_en_q <= 1'b1;
            rd_vld_q  <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        IDLE: begin
          if (cmd_valid) begin
            cmd_q  <= cmd;
            busy_q <= 1'b1;
            if (cmd == CMD_WRITE) begin
              irb_rw_q <= 1'b0;
              irb_a_q  <= '0;
              irb_d_q  <= buf_q[0];
              state_q  <= WRITE;
            end else begin
              state_q <= EXEC;
            end
          end
        end
        EXEC: begin
          case (cmd_e'(cmd_q))
            CMD_UP:    if (y_q != P_ONE) y_q <= y_q - P_ONE;
            CMD_DOWN:  if (y_q != P_MAX) y_q <= y_q + P_ONE;
            CMD_LEFT:  if (x_q != P_ONE) x_q <= x_q - P_ONE;
            CMD_RIGHT: if (x_q != P_MAX) x_q <= x_q + P_ONE;
            default: ;
          endcase
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        WRITE: begin
          if (irb_a_q == A_LAST) begin
            irb_rw_q <= 1'b1;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else begin
            irb_a_q <= irb_nxt;
            irb_d_q <= buf_q[irb_nxt];
          end
        end
      endcase
    end
  end

  assign IROM_EN = irom_en_q;
  assign IROM_A  = irom_a_q;
  assign IRB_RW  = irb_rw_q;
  assign IRB_D   = irb_d_q;
  assign IRB_A   = irb_a_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_lcd_ctrl_gen.sv
// tb/tb_lcd_ctrl_gen.sv - directed self-checking bench for lcd_ctrl_gen (default 8x8, 8-bit)
// Expectations for cmd 11 follow LCD_CTRL_ROTATE_EN.
module tb_lcd_ctrl_gen;

  localparam int N = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cmd = 4'd0;
  logic       cmd_valid = 1'b0;
  logic [7:0] irom_q = 8'd0;
  logic       irom_en, irb_rw, busy, done;
  logic [5:0] irom_a, irb_a;
  logic [7:0] irb_d;

  logic [7:0] irb [N];
  int         exp_img [N];
  int         tests = 0;
  int         fails = 0;
  int         done_cnt = 0;
  int         wr_cnt = 0;

  lcd_ctrl_gen dut (
    .clk       (clk),
    .reset     (rst),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .IROM_Q    (irom_q),
    .IROM_EN   (irom_en),
    .IROM_A    (irom_a),
    .IRB_RW    (irb_rw),
    .IRB_D     (irb_d),
    .IRB_A     (irb_a),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // IROM holds IROM[k] = k; synchronous read.
  always @(posedge clk) irom_q <= {2'b00, irom_a};

  always @(posedge clk) begin
    if (!irb_rw) begin
      irb[irb_a] <= irb_d;
      wr_cnt     <= wr_cnt + 1;
    end
  end

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic reset_img();
    for (int k = 0; k < N; k++) exp_img[k] = k;
  endtask

  task automatic do_reset();
    int n;
    rst = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_irom_en", irom_en, 1);
    chk("rst_irom_a", irom_a, 0);
    chk("rst_irb_rw", irb_rw, 1);
    chk("rst_irb_a", irb_a, 0);
    chk("rst_irb_d", irb_d, 0);
    rst = 1'b0;
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!busy) break;
    end
    chk("busy_fall_edges", n, N + 2);
    reset_img();
  endtask

  task automatic send_cmd(input logic [3:0] c);
    cmd = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk($sformatf("busy_after_cmd%0d", c), busy, 1);
    if (c != 4'd0) begin
      @(negedge clk);
      chk($sformatf("busy_one_cycle_cmd%0d", c), busy, 0);
    end
  endtask

  task automatic do_write(input string tag);
    int n, d0, w0;
    d0 = done_cnt;
    w0 = wr_cnt;
    send_cmd(4'd0);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_busy_at_done"}, busy, 0);
    @(negedge clk);
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    chk({tag, "_write_count"}, wr_cnt - w0, N);
    for (int k = 0; k < N; k++)
      chk($sformatf("%s_irb%0d", tag, k), irb[k], exp_img[k]);
  endtask

  initial begin
    int n, d0;

    // Average at the centre window, then two back-to-back dumps.
    do_reset();
    send_cmd(4'd5);
    exp_img[27] = 31; exp_img[28] = 31; exp_img[35] = 31; exp_img[36] = 31;
    do_write("avg");
    do_write("avg_rewrite");

    // Up saturates at y=1, then mirror X.
    do_reset();
    repeat (5) send_cmd(4'd1);
    send_cmd(4'd6);
    exp_img[3] = 11; exp_img[4] = 12; exp_img[11] = 3; exp_img[12] = 4;
    do_write("up_mirx");

    do_reset();
    send_cmd(4'd8);
    exp_img[27] = 36; exp_img[28] = 36; exp_img[35] = 36; exp_img[36] = 36;
    do_write("max");

    do_reset();
    send_cmd(4'd9);
    exp_img[27] = 27; exp_img[28] = 27; exp_img[35] = 27; exp_img[36] = 27;
    do_write("min");

    do_reset();
    send_cmd(4'd11);
`ifdef LCD_CTRL_ROTATE_EN
    exp_img[27] = 35; exp_img[28] = 27; exp_img[36] = 28; exp_img[35] = 36;
`endif
    do_write("rot_cw");

    // Right saturates at x=7; window (6..7, 3..4) = 30,31,38,39 -> 34.
    do_reset();
    repeat (4) send_cmd(4'd4);
    send_cmd(4'd5);
    exp_img[30] = 34; exp_img[31] = 34; exp_img[38] = 34; exp_img[39] = 34;
    do_write("right_avg");

    // cmd_valid held through the busy cycle: only one left shift, x=3.
    do_reset();
    cmd = 4'd3;
    cmd_valid = 1'b1;
    @(negedge clk);
    chk("held_busy_accept", busy, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("held_busy_release", busy, 0);
    send_cmd(4'd7);
    exp_img[26] = 27; exp_img[27] = 26; exp_img[34] = 35; exp_img[35] = 34;
    do_write("held_left_miry");

    // Reset in the middle of a dump.
    d0 = done_cnt;
    cmd = 4'd0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (irb_a != 6'd20 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("midwr_reached_20", irb_a, 20);
    chk("midwr_rw_low", irb_rw, 0);
    #1 rst = 1'b1;
    #1;
    chk("midwr_rst_rw", irb_rw, 1);
    chk("midwr_rst_busy", busy, 1);
    chk("midwr_rst_done", done, 0);
    chk("midwr_rst_irb_a", irb_a, 0);
    do_reset();
    chk("midwr_no_done", done_cnt - d0, 0);
    do_write("after_midwr");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl_gen.md
Name: lcd_ctrl_gen

Overview:
- Parametrised next-generation LCD image controller.
- Loads an IMG_DIM x IMG_DIM image from IROM into an internal buffer, then applies host commands to a 2x2 window around a movable operation point.
- On the write command, dumps the buffer to IRB.
- Generalises the 8x8/8-bit controller in image size and pixel width, and adds max/min, optional rotate, and repeatable write.

Parameters:
- IMG_DIM, 8, image side length; power of two, >= 4.
- PIX_W, 8, pixel width in bits.
- (localparam) AW, 2*log2(IMG_DIM), linear pixel address width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd  in  4  command code.
- cmd_valid  in  1  cmd qualifier.
- IROM_Q  in  PIX_W  IROM read data; valid one cycle after address.
- IROM_EN  out  1  IROM chip enable, active-low.
- IROM_A  out  AW  IROM address.
- IRB_RW  out  1  IRB write enable, active-low (1 = idle/read).
- IRB_D  out  PIX_W  IRB write data.
- IRB_A  out  AW  IRB address.
- busy  out  1  high = command not accepted.
- done  out  1  one-cycle pulse when a write dump completes.

Behaviour:
- Reset values: busy=1, done=0, IROM_EN=1, IROM_A=0, IRB_RW=1, IRB_A=0, IRB_D=0, point (x,y)=(IMG_DIM/2, IMG_DIM/2), state LOAD.
- Addressing: row-major, addr = row*IMG_DIM + col.
- Window cells:
  - TL = (x-1, y-1), TR = (x, y-1), BL = (x-1, y), BR = (x, y).
  - x and y are each in 1..IMG_DIM-1.
- LOAD state:
  - IROM_EN=0; IROM_A steps 0..N-1 (N = IMG_DIM^2), one per cycle.
  - IROM_Q is captured into buffer[a] one cycle after address a is driven.
  - After the last capture: IROM_EN=1, busy=0, go to IDLE.
  - busy falls exactly N+2 rising edges after reset deassertion.
- IDLE state: cmd is accepted on a rising edge when cmd_valid=1 and busy=0. busy is 1 from the following cycle. cmd_valid while busy=1 is ignored.
- EXEC state (single-cycle commands): result is written to the buffer on the cycle after acceptance. busy is high for exactly one cycle, then returns to IDLE.
  - 1 up: y-1. 2 down: y+1. 3 left: x-1. 4 right: x+1. All saturate at 1 or IMG_DIM-1; at a boundary the command is a no-op but still takes its busy cycle.
  - 5 average: all four cells = floor(sum/4). Sum is computed in PIX_W+2 bits, no overflow.
  - 6 mirror X: swap TL<->BL and TR<->BR.
  - 7 mirror Y: swap TL<->TR and BL<->BR.
  - 8 max: all four cells = maximum of the four (unsigned).
  - 9 min: all four cells = minimum of the four (unsigned).
  - 10/11: rotate (see Optional Feature).
  - 12-15: reserved, no-op, one busy cycle.
- WRITE state (cmd 0):
  - IRB_RW=0; IRB_A steps 0..N-1, one per cycle, with IRB_D=buffer[IRB_A].
  - After the last write: IRB_RW=1, done=1 for one cycle, busy=0 in the same cycle.
  - Buffer and point are retained; further commands and further writes are permitted.
- Reset mid-operation (any state): outputs return to reset values immediately. A WRITE in progress is abandoned with no done pulse. The image is reloaded from address 0.

Optional Feature:
- Macro: LCD_CTRL_ROTATE_EN.
- Defined:
  - cmd 10 rotates counter-clockwise: TL<-TR, TR<-BR, BR<-BL, BL<-TL.
  - cmd 11 rotates clockwise: TL<-BL, TR<-TL, BR<-TR, BL<-BR.
- Undefined: cmds 10 and 11 behave as reserved no-ops (one busy cycle, buffer unchanged).

Decomposition:
- Package lcd_ctrl_gen_pkg: cmd enum (CMD_WRITE..CMD_ROT_CW), state enum (LOAD, IDLE, EXEC, WRITE), default-parameter constants.
- Sub-module lcd_win_alu: purely combinational. Inputs are cmd plus the four window pixels; outputs are the four result pixels. Contains all window arithmetic, including the rotate paths under the macro.

Test Plan:
- Defaults, IROM[k]=k, cmd 5 then 0 -> IRB[27]=IRB[28]=IRB[35]=IRB[36]=31 (floor of 126/4), all other IRB[k]=k, done pulses once, busy low in the done cycle.
- cmd 1 issued x5 from reset, then 6, then 0 -> y saturates at 1. Writes IRB[3]=11, IRB[4]=12, IRB[11]=3, IRB[12]=4; no other addresses change.
- cmd 8 at (4,4), then 0 -> IRB[27,28,35,36]=36. Separate run with cmd 9 -> those four addresses = 27.
- LCD_CTRL_ROTATE_EN defined, cmd 11 then 0 -> IRB[27]=35, IRB[28]=27, IRB[36]=28, IRB[35]=36. Macro undefined -> unchanged values, busy high for one cycle.
- Assert reset while IRB_A=20 during WRITE -> IRB_RW=1, busy=1, done=0 in the same cycle. IROM reload restarts at address 0, and busy falls N+2 cycles after release.
- cmd_valid held high with cmd 3 while busy -> no additional shift; exactly one shift per accepted handshake.
